sram_mem_controller: RTL and testbench

//  Sequences the MEM stage's data access onto an external 16-bit asynchronous SRAM.
//  - Splits each 32-bit word into two 16-bit SRAM accesses, then stretches the access to a fixed cycle count.
//  - Drives ready low while busy; the pipeline derives freeze = ~ready for the IF/ID/EX/MEM stage registers.
//  - Sits between the EX/MEM stage register outputs and the MEM/WB stage register MEM_read_value input.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/sram_mem_controller.sv | 140 ++++++++++++++
 tb/tb_sram_mem_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the SRAM data-memory controller.
//   - One-hot FSM state encoding (IDLE, LO, HI, WAIT, DONE).
//   - Default values for the data-memory base address, the SRAM address
//     width and the fixed access length.
package mem_ctrl_pkg;

  localparam int ACCESS_CYCLES_DEF = 6;
  localparam int BASE_ADDR_DEF     = 1024;
  localparam int SRAM_AW_DEF       = 18;

  // One-hot so every output decode is a single flop bit and cannot glitch.
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_LO   = 5'b00010,
    ST_HI   = 5'b00100,
    ST_WAIT = 5'b01000,
    ST_DONE = 5'b10000
  } state_e;

endpackage

// File: rtl/sram_mem_controller.sv
// Sequences a 32-bit MEM-stage data access onto a 16-bit asynchronous SRAM.
// Each word is moved as two halfword accesses (low half at the even SRAM
// address, high half at the odd one), then the access is stretched so that
// ready rises exactly ACCESS_CYCLES cycles after the request is first seen.
// The pipeline freezes on ~ready. ACCESS_CYCLES must be at least 4.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   wr_en, rd_en store / load request; both set is treated as a store
//   address      byte address, bits [1:0] ignored
//   write_data   store data
//   read_data    assembled load data, held until the next load or reset
//   ready        1 = no access pending, or access completing this cycle
//   sram_addr    SRAM halfword address
//   sram_dq_o    SRAM write data
//   sram_dq_oe   1 = controller drives the DQ bus
//   sram_dq_i    SRAM read data
//   sram_we_n    SRAM write enable, active-low
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int BASE_ADDR     = BASE_ADDR_DEF,
  parameter int SRAM_AW       = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n
);

  // WAIT counts 0..ACCESS_CYCLES-5; sized for that range only.
  localparam int CNT_W = (ACCESS_CYCLES > 5) ? $clog2(ACCESS_CYCLES - 4) : 1;
  localparam int CNT_LAST_I = (ACCESS_CYCLES > 4) ? (ACCESS_CYCLES - 5) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
  localparam logic [31:0] BASE_VEC = 32'(BASE_ADDR);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        read_data_q, read_data_d;

  logic               req;
  logic               is_wr;
  logic               is_rd;
  logic [SRAM_AW:0]   eff;
  logic [SRAM_AW-1:0] lo_addr;
  logic [SRAM_AW-1:0] hi_addr;
  logic               unused_addr_bits;

  assign req   = wr_en | rd_en;
  assign is_wr = wr_en;
  assign is_rd = rd_en & ~wr_en;

  // Only the low SRAM_AW+1 bits of the rebased address reach the SRAM, and
  // a subtraction's low bits depend only on the operands' low bits.
  assign eff     = address[SRAM_AW:0] - BASE_VEC[SRAM_AW:0];
  assign lo_addr = {eff[SRAM_AW:2], 1'b0};
  assign hi_addr = lo_addr | SRAM_AW'(1);

  assign unused_addr_bits = ^{address[31:SRAM_AW+1], eff[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    sram_addr   = '0;
    sram_dq_o   = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    ready       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready = ~req;
        if (req) state_d = ST_LO;
      end
      ST_LO: begin
        sram_addr = lo_addr;
        if (is_wr) begin
          sram_dq_o  = write_data[15:0];
          sram_dq_oe = 1'b1;
          sram_we_n  = 1'b0;
        end
        if (is_rd) read_data_d[15:0] = sram_dq_i;
        state_d = ST_HI;
      end
      ST_HI: begin
        sram_addr = hi_addr;
        if (is_wr) begin
          sram_dq_o  = write_data[31:16];
          sram_dq_oe = 1'b1;
          sram_we_n  = 1'b0;
        end
        if (is_rd) read_data_d[31:16] = sram_dq_i;
        state_d = (ACCESS_CYCLES > 4) ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Always return to IDLE: the pipeline advances on this edge, so any
        // request seen in IDLE afterwards is a new one, never a re-issue.
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
module tb_sram_mem_controller;

  typedef struct {
    logic [31:0] rd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en [2];
  logic        rd_en [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic [17:0] saddr [2];
  logic [15:0] dqo   [2];
  logic        oe    [2];
  logic [15:0] dqi   [2];
  logic        we_n  [2];
  logic [15:0] mem   [2][256];

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  logic [33:0] wtrace[$];
  int          cyc[2];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Instance 0: default 6-cycle access. Instance 1: minimum 4-cycle access.
  sram_mem_controller #(.ACCESS_CYCLES(6)) dut6 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
    .address(addr[0]), .write_data(wd[0]), .read_data(rdata[0]),
    .ready(rdy[0]), .sram_addr(saddr[0]), .sram_dq_o(dqo[0]),
    .sram_dq_oe(oe[0]), .sram_dq_i(dqi[0]), .sram_we_n(we_n[0]));

  sram_mem_controller #(.ACCESS_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
    .address(addr[1]), .write_data(wd[1]), .read_data(rdata[1]),
    .ready(rdy[1]), .sram_addr(saddr[1]), .sram_dq_o(dqo[1]),
    .sram_dq_oe(oe[1]), .sram_dq_i(dqi[1]), .sram_we_n(we_n[1]));

  // Behavioural SRAM per instance: combinational read, write while we_n=0.
  assign dqi[0] = mem[0][saddr[0][7:0]];
  assign dqi[1] = mem[1][saddr[1][7:0]];
  always @(posedge clk) begin
    if (!we_n[0]) mem[0][saddr[0][7:0]] <= dqo[0];
    if (!we_n[1]) mem[1][saddr[1][7:0]] <= dqo[1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Completion monitor: counts cycles a request is outstanding and checks
  // latency and read data against the scoreboard when ready rises.
  task automatic mon(input int i);
    exp_t e;
    if (rst || !(wr_en[i] || rd_en[i])) begin
      cyc[i] = 0;
    end else if (!rdy[i]) begin
      cyc[i]++;
    end else begin
      if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_completion inst%0d: got ready=1, expected none", i);
      end else begin
        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("latency_inst%0d", i), 64'(cyc[i] + 1), 64'(e.lat));
        chk($sformatf("read_data_inst%0d", i), 64'(rdata[i]), 64'(e.rd));
      end
      cyc[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!we_n[0]) wtrace.push_back({saddr[0][17:0] == 18'(saddr[0][7:0]) ? saddr[0][7:0] : 8'hFF,
                                    10'd0, dqo[0]});
    mon(0);
    mon(1);
  end

  task automatic start(input int i, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] erd, input int lat,
                       input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    wr_en[i] = w;
    rd_en[i] = r;
    addr[i]  = a;
    wd[i]    = d;
    e.rd  = erd;
    e.lat = lat;
    if (push) begin
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  task automatic wait_done(input int i);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rdy[i] && k < 30);
    if (!rdy[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout inst%0d: got no ready in 30 cycles, expected ready", i);
    end
  endtask

  task automatic end_req(input int i);
    @(posedge clk);
    #1;
    wr_en[i] = 1'b0;
    rd_en[i] = 1'b0;
  endtask

  task automatic single(input int i, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] erd, input int lat);
    start(i, w, r, a, d, erd, lat, 1'b1);
    wait_done(i);
    end_req(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      wr_en[i] = 1'b0; rd_en[i] = 1'b0; addr[i] = '0; wd[i] = '0; cyc[i] = 0;
      for (int j = 0; j < 256; j++) mem[i][j] = 16'h0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), 64'(rdy[i]), 64'd1);
      chk($sformatf("rst_we_n%0d", i), 64'(we_n[i]), 64'd1);
      chk($sformatf("rst_oe%0d", i), 64'(oe[i]), 64'd0);
      chk($sformatf("rst_addr%0d", i), 64'(saddr[i]), 64'd0);
      chk($sformatf("rst_dq_o%0d", i), 64'(dqo[i]), 64'd0);
      chk($sformatf("rst_rdata%0d", i), 64'(rdata[i]), 64'd0);
    end

    // 1: write 0xDEADBEEF to 1032 -> halfwords 4 and 5.
    wtrace.delete();
    single(0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 32'h0, 6);
    chk("t1_we_cycles", 64'(wtrace.size()), 64'd2);
    if (wtrace.size() == 2) begin
      chk("t1_lo", 64'(wtrace[0]), 64'({8'd4, 10'd0, 16'hBEEF}));
      chk("t1_hi", 64'(wtrace[1]), 64'({8'd5, 10'd0, 16'hDEAD}));
    end

    // 2: read it back; read_data then holds.
    single(0, 1'b0, 1'b1, 32'd1032, 32'h0, 32'hDEADBEEF, 6);
    repeat (3) @(negedge clk);
    chk("t2_rdata_hold", 64'(rdata[0]), 64'hDEADBEEF);

    // 3: idle bus for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t3_ready", 64'(rdy[0]), 64'd1);
      chk("t3_we_n", 64'(we_n[0]), 64'd1);
      chk("t3_oe", 64'(oe[0]), 64'd0);
      chk("t3_addr", 64'(saddr[0]), 64'd0);
    end

    // 4: both enables set -> write; read_data keeps 0xDEADBEEF.
    wtrace.delete();
    single(0, 1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, 6);
    chk("t4_mem0", 64'(mem[0][0]), 64'h5678);
    chk("t4_mem1", 64'(mem[0][1]), 64'h1234);
    chk("t4_we_cycles", 64'(wtrace.size()), 64'd2);

    // 5: reset in the HI cycle of a write to 1028; only the low half lands.
    start(0, 1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 32'h0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_in_hi_addr", 64'(saddr[0]), 64'd3);
    chk("t5_in_hi_we_n", 64'(we_n[0]), 64'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_we_n", 64'(we_n[0]), 64'd1);
    chk("t5_rst_oe", 64'(oe[0]), 64'd0);
    chk("t5_rst_rdata", 64'(rdata[0]), 64'd0);
    wr_en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", 64'(rdy[0]), 64'd1);
    chk("t5_mem2", 64'(mem[0][2]), 64'hF00D);
    chk("t5_mem3", 64'(mem[0][3]), 64'h0000);

    // 6: back-to-back reads 1024 then 1028.
    start(0, 1'b0, 1'b1, 32'd1024, 32'h0, 32'h12345678, 6, 1'b1);
    wait_done(0);
    start(0, 1'b0, 1'b1, 32'd1028, 32'h0, 32'h0000F00D, 6, 1'b1);
    @(negedge clk);
    chk("t6_idle_gap_ready", 64'(rdy[0]), 64'd0);
    wait_done(0);
    end_req(0);
    @(negedge clk);
    chk("t6_ready_after", 64'(rdy[0]), 64'd1);

    // 6b: ACCESS_CYCLES=4 -> write then read, 4 cycles each.
    single(1, 1'b1, 1'b0, 32'd1024, 32'hA5A55A5A, 32'h0, 4);
    chk("t6b_mem0", 64'(mem[1][0]), 64'h5A5A);
    chk("t6b_mem1", 64'(mem[1][1]), 64'hA5A5);
    single(1, 1'b0, 1'b1, 32'd1024, 32'h0, 32'hA5A55A5A, 4);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty0", 64'(exp_q0.size()), 64'd0);
    chk("scoreboard_empty1", 64'(exp_q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
